// File: rtl/riscv_opcode_pkg.sv
// RV32I major-opcode constants and the one-hot instruction-class flag struct.
// TYPE_DECODE_SYSTEM_EN adds the fence (MISC-MEM) and sys (SYSTEM) class flags.
package riscv_opcode_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
`ifdef TYPE_DECODE_SYSTEM_EN
    logic sys;
    logic fence;
`endif
    logic j;
    logic lui;
    logic aui;
    logic sb;
    logic s;
    logic jr;
    logic l;
    logic i;
    logic r;
  } instr_class_t;

endpackage

// File: rtl/type_decode_comb.sv
// Pure combinational opcode-to-class decode; illegal when qualified and nothing matches.
// TYPE_DECODE_SYSTEM_EN enables decoding of MISC-MEM and SYSTEM opcodes.
module type_decode_comb
  import riscv_opcode_pkg::*;
(
  input  logic         valid,
  input  logic [6:0]   opcode,
  output instr_class_t cls,
  output logic         illegal
);

  always_comb begin
    cls = '0;
    if (valid) begin
      case (opcode)
        OPC_OP:       cls.r     = 1'b1;
        OPC_OP_IMM:   cls.i     = 1'b1;
        OPC_LOAD:     cls.l     = 1'b1;
        OPC_JALR:     cls.jr    = 1'b1;
        OPC_STORE:    cls.s     = 1'b1;
        OPC_BRANCH:   cls.sb    = 1'b1;
        OPC_AUIPC:    cls.aui   = 1'b1;
        OPC_LUI:      cls.lui   = 1'b1;
        OPC_JAL:      cls.j     = 1'b1;
`ifdef TYPE_DECODE_SYSTEM_EN
        OPC_MISC_MEM: cls.fence = 1'b1;
        OPC_SYSTEM:   cls.sys   = 1'b1;
`endif
        default:      cls       = '0;
      endcase
    end
  end

  // Exact 7-bit compares mean opcodes with [1:0] != 2'b11 never match, so they fall out as illegal here.
  assign illegal = valid && (cls == '0);

endmodule

// File: rtl/type_decode.sv
// RV32I instruction-class decoder with optional output register (OUT_REG=1: 1-cycle latency).
// TYPE_DECODE_SYSTEM_EN adds the fence and sys outputs.
module type_decode
  import riscv_opcode_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [6:0] opcode,
  output logic       valid_o,
  output logic       R,
  output logic       I,
  output logic       L,
  output logic       Jr,
  output logic       S,
  output logic       Sb,
  output logic       aui,
  output logic       lui,
  output logic       J,
`ifdef TYPE_DECODE_SYSTEM_EN
  output logic       fence,
  output logic       sys,
`endif
  output logic       illegal
);

  instr_class_t cls_c;
  logic         illegal_c;
  instr_class_t cls_o;
  logic         illegal_o;
  logic         valid_out;

  type_decode_comb u_comb (
    .valid   (valid_i),
    .opcode  (opcode),
    .cls     (cls_c),
    .illegal (illegal_c)
  );

  generate
    if (OUT_REG != 0) begin : g_reg
      instr_class_t cls_q;
      logic         illegal_q;
      logic         valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cls_q     <= '0;
          illegal_q <= 1'b0;
          valid_q   <= 1'b0;
        end else begin
          cls_q     <= cls_c;
          illegal_q <= illegal_c;
          valid_q   <= valid_i;
        end
      end

      assign cls_o     = cls_q;
      assign illegal_o = illegal_q;
      assign valid_out = valid_q;
    end else begin : g_comb
      // Combinational build ignores clk/rst_n entirely: reset must not disturb a live decode.
      assign cls_o     = cls_c;
      assign illegal_o = illegal_c;
      assign valid_out = valid_i;
    end
  endgenerate

  assign valid_o = valid_out;
  assign R       = cls_o.r;
  assign I       = cls_o.i;
  assign L       = cls_o.l;
  assign Jr      = cls_o.jr;
  assign S       = cls_o.s;
  assign Sb      = cls_o.sb;
  assign aui     = cls_o.aui;
  assign lui     = cls_o.lui;
  assign J       = cls_o.j;
`ifdef TYPE_DECODE_SYSTEM_EN
  assign fence   = cls_o.fence;
  assign sys     = cls_o.sys;
`endif
  assign illegal = illegal_o;

endmodule

// File: tb/tb_type_decode.sv
// Scoreboard bench for type_decode: registered instance checked by a monitor, combinational instance checked inline.
module tb_type_decode;

`ifdef TYPE_DECODE_SYSTEM_EN
  localparam int NF = 11;
`else
  localparam int NF = 9;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_i = 1'b0;
  logic [6:0] opcode = '0;

  logic r_vo, r_R, r_I, r_L, r_Jr, r_S, r_Sb, r_aui, r_lui, r_J, r_ill;
  logic c_vo, c_R, c_I, c_L, c_Jr, c_S, c_Sb, c_aui, c_lui, c_J, c_ill;
  logic [NF:0] r_vec, c_vec;

  int tests = 0;
  int fails = 0;
  bit in_reset = 1'b1;
  logic [NF:0] exp_q[$];

  // Bit k of the model vector is the class of known[k]; bit NF is illegal.
  bit [6:0] known [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                           7'b1100011, 7'b0010111, 7'b0110111, 7'b1101111,
                           7'b0001111, 7'b1110011};

  always #5 clk = ~clk;

`ifdef TYPE_DECODE_SYSTEM_EN
  logic r_fence, r_sys, c_fence, c_sys;
  assign r_vec = {r_ill, r_sys, r_fence, r_J, r_lui, r_aui, r_Sb, r_S, r_Jr, r_L, r_I, r_R};
  assign c_vec = {c_ill, c_sys, c_fence, c_J, c_lui, c_aui, c_Sb, c_S, c_Jr, c_L, c_I, c_R};
`else
  assign r_vec = {r_ill, r_J, r_lui, r_aui, r_Sb, r_S, r_Jr, r_L, r_I, r_R};
  assign c_vec = {c_ill, c_J, c_lui, c_aui, c_Sb, c_S, c_Jr, c_L, c_I, c_R};
`endif

  type_decode #(.OUT_REG(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .opcode(opcode), .valid_o(r_vo),
    .R(r_R), .I(r_I), .L(r_L), .Jr(r_Jr), .S(r_S), .Sb(r_Sb), .aui(r_aui), .lui(r_lui), .J(r_J),
`ifdef TYPE_DECODE_SYSTEM_EN
    .fence(r_fence), .sys(r_sys),
`endif
    .illegal(r_ill)
  );

  type_decode #(.OUT_REG(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .opcode(opcode), .valid_o(c_vo),
    .R(c_R), .I(c_I), .L(c_L), .Jr(c_Jr), .S(c_S), .Sb(c_Sb), .aui(c_aui), .lui(c_lui), .J(c_J),
`ifdef TYPE_DECODE_SYSTEM_EN
    .fence(c_fence), .sys(c_sys),
`endif
    .illegal(c_ill)
  );

  function automatic logic [NF:0] model(bit v, bit [6:0] op);
    logic [NF:0] res = '0;
    if (!v) return res;
    for (int k = 0; k < NF; k++)
      if (known[k] == op) res[k] = 1'b1;
    if (res == '0) res[NF] = 1'b1;
    return res;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of input; the registered decode is expected one cycle later.
  task automatic issue(bit v, bit [6:0] op);
    @(posedge clk);
    #1;
    valid_i = v;
    opcode  = op;
    if (v) exp_q.push_back(model(v, op));
    #1;
    chk("comb_flags", 32'(c_vec), 32'(model(v, op)));
    chk("comb_valid", 32'(c_vo), 32'(v));
  endtask

  always @(negedge clk) begin
    if (!in_reset) begin
      if (r_vo) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid_o", 32'(r_vo), 32'd0);
        end else begin
          automatic logic [NF:0] e = exp_q.pop_front();
          chk("reg_flags", 32'(r_vec), 32'(e));
        end
      end else begin
        chk("idle_flags", 32'(r_vec), 32'd0);
      end
    end
  end

  initial begin
    // Reset asserted with a live opcode: registered outputs clear without a clock edge.
    valid_i = 1'b1;
    opcode  = 7'b0110011;
    #2;
    chk("reset_flags", 32'(r_vec), 32'd0);
    chk("reset_valid", 32'(r_vo), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hold_flags", 32'(r_vec), 32'd0);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(model(1'b1, 7'b0110011));
    in_reset = 1'b0;

    for (int k = 0; k < 9; k++) issue(1'b1, known[k]);
    issue(1'b1, 7'b0001111);
    issue(1'b1, 7'b0110000);
    issue(1'b1, 7'b1111111);
    issue(1'b0, 7'b1101111);
    issue(1'b1, 7'b1110011);

    for (int n = 0; n < 300; n++) begin
      automatic bit v = ($urandom_range(0, 4) != 0);
      automatic bit [6:0] op = ($urandom_range(0, 9) < 6) ? known[$urandom_range(0, 10)]
                                                          : 7'($urandom);
      issue(v, op);
      // Occasional mid-stream reset: the in-flight decode is discarded.
      if (n == 150) begin
        #2;
        in_reset = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midreset_flags", 32'(r_vec), 32'd0);
        chk("midreset_valid", 32'(r_vo), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        valid_i = 1'b0;
        in_reset = 1'b0;
      end
    end

    // Combinational build ignores reset.
    issue(1'b1, 7'b0100011);
    #1;
    in_reset = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("comb_reset_S", 32'(c_S), 32'd1);
    chk("comb_reset_valid", 32'(c_vo), 32'd1);
    chk("reg_reset_S", 32'(r_S), 32'd0);
    exp_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    valid_i = 1'b0;
    in_reset = 1'b0;

    issue(1'b1, 7'b1101111);
    issue(1'b0, 7'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
